// File: rtl/st_m_seq_tx_if.sv
// Symbol push channel into the st_m sequence transmitter.
// The upstream agent is the master; the transmitter FIFO is the slave.
interface st_m_seq_tx_if #(
    parameter int HOLD_W = 3
);
    logic              sym_valid;
    logic              sym_ready;
    logic [1:0]        sym_code;
    logic [HOLD_W-1:0] sym_hold;

    modport master (output sym_valid, output sym_code, output sym_hold, input sym_ready);
    modport slave  (input sym_valid, input sym_code, input sym_hold, output sym_ready);
endinterface

// File: rtl/st_m_seq_tx.sv
// Plays queued one-hot symbols onto tx_data for the st_m controller; optional ST_TX_CNT_EN adds tx_count.
// Latency: tx_data is loaded on the edge that sees start; each symbol lasts 1+hold cycles.
// Backpressure: sym_ready drops only while the 4-entry FIFO is full; pushes are accepted in any state.
module st_m_seq_tx #(
    parameter int inp_len = 3,
    parameter int DEPTH   = 4,
    parameter int PTR_W   = 2,
    parameter int HOLD_W  = 3
) (
    input  logic               clock,
    input  logic               reset,
    st_m_seq_tx_if.slave       sym,
    input  logic               start,
    output logic [inp_len-1:0] tx_data,
    output logic               tx_active,
    output logic               done,
`ifdef ST_TX_CNT_EN
    output logic [7:0]         tx_count,
`endif
    output logic               err_illegal
);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [1:0]        code;
        logic [HOLD_W-1:0] hold;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [HOLD_W-1:0] hold_cnt;
    logic              push_fire, push_ok, pop, fifo_empty;

    assign sym.sym_ready = (count != CNT_FULL);
    assign push_fire     = sym.sym_valid && sym.sym_ready;
    // Code 3 completes the handshake but is dropped so only legal codes reach tx_data.
    assign push_ok       = push_fire && (sym.sym_code != 2'd3);
    assign fifo_empty    = (count == '0);
    assign head          = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= entry_t'{code: sym.sym_code, hold: sym.sym_hold};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_illegal <= 1'b0;
        end else if (push_fire && (sym.sym_code == 2'd3)) begin
            err_illegal <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Pop decisions use the registered count, so a push into an empty FIFO waits a cycle.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (hold_cnt == '0) begin
                    if (!fifo_empty) pop       = 1'b1;
                    else             state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_active = (state == S_SEND);
        done      = (state == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_data  <= '0;
            hold_cnt <= '0;
        end else if (pop) begin
            tx_data  <= inp_len'(1) << head.code;
            hold_cnt <= head.hold;
        end else if (state == S_SEND) begin
            if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
            else                tx_data  <= '0;
        end
    end

`ifdef ST_TX_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_count <= 8'd0;
        end else if (pop && (tx_count != 8'hFF)) begin
            tx_count <= tx_count + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_st_m_seq_tx.sv
// Bench for st_m_seq_tx: directed vector table, async reset corner, random playback vs a trace model.
// Inputs change and outputs are sampled on the falling edge.
module tb_st_m_seq_tx;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] tx_data;
    logic       tx_active, done, err_illegal;
`ifdef ST_TX_CNT_EN
    logic [7:0] tx_count;
`endif
    int errors = 0;
    int checks = 0;

    st_m_seq_tx_if #(.HOLD_W(3)) sif ();

    st_m_seq_tx dut (
        .clock      (clock),
        .reset      (reset),
        .sym        (sif),
        .start      (start),
        .tx_data    (tx_data),
        .tx_active  (tx_active),
        .done       (done),
`ifdef ST_TX_CNT_EN
        .tx_count   (tx_count),
`endif
        .err_illegal(err_illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [1:0] c;
        logic [2:0] h;
        logic       s;
        logic       rdy;
        logic [2:0] dat;
        logic       act;
        logic       dn;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [1:0] c, input logic [2:0] h, input logic s,
                                input logic rdy, input logic [2:0] dat, input logic act,
                                input logic dn, input logic err);
        vec_t r;
        r.v = v; r.c = c; r.h = h; r.s = s;
        r.rdy = rdy; r.dat = dat; r.act = act; r.dn = dn; r.err = err;
        return r;
    endfunction

    function automatic logic [2:0] code_of(input int c);
        case (c)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [2:0] h, input logic s);
        sif.sym_valid = v;
        sif.sym_code  = c;
        sif.sym_hold  = h;
        start         = s;
    endtask

    task automatic push_and_wait(input logic [1:0] c, input logic [2:0] h);
        drive(1'b1, c, h, 1'b0);
        @(negedge clock);
        drive(1'b0, 2'd0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        logic [2:0] trace[$];
        int         n, nlegal, c, h;
        logic       merr;

        drive(1'b0, 2'd0, 3'd0, 1'b0);
        repeat (2) @(negedge clock);
        chk("reset_dat", tx_data, 0);
        chk("reset_act", tx_active, 0);
        chk("reset_rdy", sif.sym_ready, 1);
        chk("reset_err", err_illegal, 0);
        reset = 1'b0;
        @(negedge clock);

        // Async reset in the middle of a playback with three entries still queued
        push_and_wait(2'd3, 3'd0);
        push_and_wait(2'd0, 3'd0);
        push_and_wait(2'd1, 3'd1);
        push_and_wait(2'd2, 3'd2);
        push_and_wait(2'd0, 3'd0);
        chk("pre_full_rdy", sif.sym_ready, 0);
        drive(1'b0, 2'd0, 3'd0, 1'b1);
        @(negedge clock);
        start = 1'b0;
        chk("pre_rst_act", tx_active, 1);
        chk("pre_rst_dat", tx_data, 3'b001);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_dat", tx_data, 0);
        chk("mid_rst_act", tx_active, 0);
        chk("mid_rst_rdy", sif.sym_ready, 1);
        chk("mid_rst_err", err_illegal, 0);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("post_rst_start_act", tx_active, 0);
        chk("post_rst_start_dat", tx_data, 0);
        @(negedge clock);
        chk("post_rst_start_done", done, 0);

        //                v  c  h  s    rdy dat    act dn err
        tbl.push_back(mk(1, 1, 0, 0,   1, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 2, 2, 0,   1, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,   1, 3'b010, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b000, 0, 0, 0));
        // fill the FIFO, hold off a fifth push, then check pointer wrap
        tbl.push_back(mk(1, 0, 1, 0,   1, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0,   1, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0,   1, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,   0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0,   0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 1,   1, 3'b001, 1, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0,   0, 3'b001, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b010, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b001, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b000, 0, 0, 0));
        // illegal code is dropped, flag sticks through a normal playback
        tbl.push_back(mk(1, 3, 0, 0,   1, 3'b000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1,   1, 3'b000, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0,   1, 3'b000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1,   1, 3'b001, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b000, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b000, 0, 0, 1));
        // late push extends a running playback with no gap
        tbl.push_back(mk(1, 1, 1, 0,   1, 3'b000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1,   1, 3'b010, 1, 0, 1));
        tbl.push_back(mk(1, 2, 0, 0,   1, 3'b010, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b100, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b000, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,   1, 3'b000, 0, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].c, tbl[i].h, tbl[i].s);
            @(negedge clock);
            chk($sformatf("vec%0d_rdy", i), sif.sym_ready, tbl[i].rdy);
            chk($sformatf("vec%0d_dat", i), tx_data, tbl[i].dat);
            chk($sformatf("vec%0d_act", i), tx_active, tbl[i].act);
            chk($sformatf("vec%0d_done", i), done, tbl[i].dn);
            chk($sformatf("vec%0d_err", i), err_illegal, tbl[i].err);
        end
        drive(1'b0, 2'd0, 3'd0, 1'b0);

        do_reset();
        chk("rerst_err", err_illegal, 0);

        // Random bursts: expected output is the concatenation of each legal symbol repeated 1+hold times
        merr = 1'b0;
        for (int it = 0; it < 40; it++) begin
            trace.delete();
            n      = $urandom_range(1, 4);
            nlegal = 0;
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 1)) @(negedge clock);
                c = $urandom_range(0, 3);
                h = $urandom_range(0, 3);
                drive(1'b1, 2'(c), 3'(h), 1'b0);
                @(negedge clock);
                drive(1'b0, 2'd0, 3'd0, 1'b0);
                if (c == 3) merr = 1'b1;
                else begin
                    nlegal++;
                    for (int r = 0; r <= h; r++) trace.push_back(code_of(c));
                end
                chk($sformatf("rnd%0d_rdy", it), sif.sym_ready, (nlegal < 4) ? 1 : 0);
                chk($sformatf("rnd%0d_err", it), err_illegal, merr);
            end
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            if (trace.size() == 0) begin
                chk($sformatf("rnd%0d_empty_act", it), tx_active, 0);
                chk($sformatf("rnd%0d_empty_dat", it), tx_data, 0);
            end else begin
                foreach (trace[i]) begin
                    if (i > 0) @(negedge clock);
                    chk($sformatf("rnd%0d_dat%0d", it, i), tx_data, trace[i]);
                    chk($sformatf("rnd%0d_act%0d", it, i), tx_active, 1);
                    chk($sformatf("rnd%0d_done%0d", it, i), done, 0);
                end
                @(negedge clock);
                chk($sformatf("rnd%0d_end_done", it), done, 1);
                chk($sformatf("rnd%0d_end_dat", it), tx_data, 0);
                chk($sformatf("rnd%0d_end_act", it), tx_active, 0);
                @(negedge clock);
                chk($sformatf("rnd%0d_idle_done", it), done, 0);
            end
        end

`ifdef ST_TX_CNT_EN
        do_reset();
        chk("cnt_reset", tx_count, 0);
        for (int round = 0; round < 75; round++) begin
            for (int k = 0; k < 4; k++) push_and_wait(2'd0, 3'd0);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            repeat (5) @(negedge clock);
            if (round == 0) chk("cnt_first_round", tx_count, 4);
        end
        chk("cnt_saturated", tx_count, 255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
